// File: rtl/morse_decoder.sv
// morse_decoder: recovers the letters S..Z (codes 0-7) from on-off keyed Morse on key_in.
// Optional input filter is enabled by defining MORSE_DEBOUNCE_EN.
module morse_decoder #(
    parameter int TICKS_PER_UNIT  = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);
    localparam int            CW    = $clog2(2*TICKS_PER_UNIT+1);
    localparam logic [CW-1:0] LIMIT = CW'(2*TICKS_PER_UNIT);

    typedef enum logic [2:0] {IDLE, MARK, SPACE, DECODE, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sync_p0;
    logic          sync_p1;
    logic          key_s;
    logic          key_d;
    logic [CW-1:0] cnt;
    logic          run_done;
    logic [3:0]    pat;
    logic [2:0]    n;
    logic          ovf;
    logic [2:0]    letter_q;
    logic          hit;
    logic [2:0]    code;
    logic          accept;

    // Returns {hit, code} for an element count and dash pattern (1 = dash, newest at LSB).
    function automatic logic [3:0] match(input logic [2:0] len, input logic [3:0] bits);
        logic [3:0] r;
        r = 4'b0000;
        case ({len, bits})
            {3'd3, 4'b0000}: r = {1'b1, 3'd0};
            {3'd1, 4'b0001}: r = {1'b1, 3'd1};
            {3'd3, 4'b0001}: r = {1'b1, 3'd2};
            {3'd4, 4'b0001}: r = {1'b1, 3'd3};
            {3'd3, 4'b0011}: r = {1'b1, 3'd4};
            {3'd4, 4'b1001}: r = {1'b1, 3'd5};
            {3'd4, 4'b1011}: r = {1'b1, 3'd6};
            {3'd4, 4'b1100}: r = {1'b1, 3'd7};
            default:         r = 4'b0000;
        endcase
        return r;
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous key line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
    logic [DW-1:0] db_cnt;

    // key_s follows sync_p1 only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_s  <= 1'b0;
            db_cnt <= '0;
        end else if (sync_p1 == key_s) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES-1)) begin
            key_s  <= sync_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end
`else
    assign key_s = sync_p1;
`endif

    // cnt is the length of the run at level key_d; it restarts at 1 on each transition
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_d <= 1'b0;
            cnt   <= '0;
        end else begin
            key_d <= key_s;
            if (key_s != key_d) begin
                cnt <= CW'(1);
            end else if (cnt != LIMIT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign run_done = !key_d && (cnt == LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (key_s) state_nxt = MARK;
            MARK:   if (!key_s) state_nxt = (n == 3'd4) ? DRAIN : SPACE;
            SPACE: begin
                if (run_done) begin
                    state_nxt = DECODE;
                end else if (key_s) begin
                    state_nxt = MARK;
                end
            end
            DECODE: state_nxt = IDLE;
            DRAIN:  if (run_done) state_nxt = DECODE;
            default: state_nxt = IDLE;
        endcase
    end

    // A fifth element sets ovf so DECODE reports error even if the first four form a letter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat      <= 4'b0000;
            n        <= 3'd0;
            ovf      <= 1'b0;
            letter_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    pat <= 4'b0000;
                    n   <= 3'd0;
                    ovf <= 1'b0;
                end
                MARK: begin
                    if (!key_s) begin
                        if (n == 3'd4) begin
                            ovf <= 1'b1;
                        end else begin
                            pat <= {pat[2:0], (cnt >= LIMIT)};
                            n   <= n + 3'd1;
                        end
                    end
                end
                DECODE: if (accept) letter_q <= code;
                default: ;
            endcase
        end
    end

    assign {hit, code} = match(n, pat);
    assign accept      = hit && !ovf;

    always_comb begin
        valid  = (state == DECODE) && accept;
        error  = (state == DECODE) && !accept;
        busy   = (state != IDLE);
        letter = valid ? code : letter_q;
    end

endmodule
